// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the RV32I register file: debug has fixed priority,
// ALU and LSU alternate on contention, and the winner is registered for one cycle.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_hold,

    input  logic                  i_dbg_valid,
    input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
    input  logic [DATA_WIDTH-1:0] i_dbg_data,
    output logic                  o_dbg_ready,

    input  logic                  i_alu_valid,
    input  logic [ADDR_WIDTH-1:0] i_alu_addr,
    input  logic [DATA_WIDTH-1:0] i_alu_data,
    output logic                  o_alu_ready,

    input  logic                  i_lsu_valid,
    input  logic [ADDR_WIDTH-1:0] i_lsu_addr,
    input  logic [DATA_WIDTH-1:0] i_lsu_data,
    output logic                  o_lsu_ready,

    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_wr_address,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [3:0]            o_alu_wait_cnt
);

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_LSU = 1'b1
    } grant_e;

    grant_e                last_grant_q, last_grant_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;

    logic dbg_ready, alu_ready, lsu_ready;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        dbg_ready = 1'b0;
        alu_ready = 1'b0;
        lsu_ready = 1'b0;
        if (!rst && !i_hold) begin
            if (i_dbg_valid) begin
                dbg_ready = 1'b1;
            end else if (i_alu_valid && (!i_lsu_valid || last_grant_q == GRANT_LSU)) begin
                alu_ready = 1'b1;
            end else if (i_lsu_valid) begin
                lsu_ready = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        we_d         = 1'b0;
        addr_d       = addr_q;
        data_d       = data_q;

        if (dbg_ready) begin
            we_d   = (i_dbg_addr != '0);
            addr_d = i_dbg_addr;
            data_d = i_dbg_data;
        end else if (alu_ready) begin
            we_d         = (i_alu_addr != '0);
            addr_d       = i_alu_addr;
            data_d       = i_alu_data;
            last_grant_d = GRANT_ALU;
        end else if (lsu_ready) begin
            we_d         = (i_lsu_addr != '0);
            addr_d       = i_lsu_addr;
            data_d       = i_lsu_data;
            last_grant_d = GRANT_LSU;
        end

        // Stall profiling only: counts cycles the ALU waits, independent of hold.
        if (!i_alu_valid || alu_ready) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q != 4'd15) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_LSU;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            wait_cnt_q   <= 4'd0;
        end else begin
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign o_dbg_ready    = dbg_ready;
    assign o_alu_ready    = alu_ready;
    assign o_lsu_ready    = lsu_ready;
    assign o_we           = we_q;
    assign o_wr_address   = addr_q;
    assign o_wr_data      = data_q;
    assign o_alu_wait_cnt = wait_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: inputs change 1 time unit after each
// rising edge, outputs are sampled before the next edge.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_hold;
    logic        i_dbg_valid, i_alu_valid, i_lsu_valid;
    logic [4:0]  i_dbg_addr, i_alu_addr, i_lsu_addr;
    logic [31:0] i_dbg_data, i_alu_data, i_lsu_data;
    logic        o_dbg_ready, o_alu_ready, o_lsu_ready;
    logic        o_we;
    logic [4:0]  o_wr_address;
    logic [31:0] o_wr_data;
    logic [3:0]  o_alu_wait_cnt;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_hold        (i_hold),
        .i_dbg_valid   (i_dbg_valid),
        .i_dbg_addr    (i_dbg_addr),
        .i_dbg_data    (i_dbg_data),
        .o_dbg_ready   (o_dbg_ready),
        .i_alu_valid   (i_alu_valid),
        .i_alu_addr    (i_alu_addr),
        .i_alu_data    (i_alu_data),
        .o_alu_ready   (o_alu_ready),
        .i_lsu_valid   (i_lsu_valid),
        .i_lsu_addr    (i_lsu_addr),
        .i_lsu_data    (i_lsu_data),
        .o_lsu_ready   (o_lsu_ready),
        .o_we          (o_we),
        .o_wr_address  (o_wr_address),
        .o_wr_data     (o_wr_data),
        .o_alu_wait_cnt(o_alu_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_ready(input string tag, input logic d, input logic a, input logic l);
        check({tag, "_dbg_ready"}, 32'(o_dbg_ready), 32'(d));
        check({tag, "_alu_ready"}, 32'(o_alu_ready), 32'(a));
        check({tag, "_lsu_ready"}, 32'(o_lsu_ready), 32'(l));
    endtask

    task automatic idle_inputs();
        i_hold      = 1'b0;
        i_dbg_valid = 1'b0;
        i_alu_valid = 1'b0;
        i_lsu_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        i_dbg_addr = '0; i_dbg_data = '0;
        i_alu_addr = '0; i_alu_data = '0;
        i_lsu_addr = '0; i_lsu_data = '0;

        // Reset: no ready even with a pending request.
        tick();
        i_alu_valid = 1'b1;
        settle();
        check_ready("rst", 1'b0, 1'b0, 1'b0);
        i_alu_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("rst_we", 32'(o_we), 32'd0);
        check("rst_addr", 32'(o_wr_address), 32'd0);
        check("rst_data", o_wr_data, 32'd0);
        check("rst_wait", 32'(o_alu_wait_cnt), 32'd0);
        check_ready("idle", 1'b0, 1'b0, 1'b0);

        // Single ALU write.
        i_alu_valid = 1'b1; i_alu_addr = 5'd5; i_alu_data = 32'hDEADBEEF;
        settle();
        check_ready("alu1", 1'b0, 1'b1, 1'b0);
        tick();
        i_alu_valid = 1'b0;
        check("alu1_we", 32'(o_we), 32'd1);
        check("alu1_addr", 32'(o_wr_address), 32'd5);
        check("alu1_data", o_wr_data, 32'hDEADBEEF);
        tick();
        check("alu1_we_drop", 32'(o_we), 32'd0);
        check("alu1_addr_hold", 32'(o_wr_address), 32'd5);

        // Fresh reset so the ALU wins the first tie again.
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();

        // ALU/LSU contention alternates, ALU first.
        i_alu_valid = 1'b1; i_alu_addr = 5'd1; i_alu_data = 32'h0000_00A1;
        i_lsu_valid = 1'b1; i_lsu_addr = 5'd2; i_lsu_data = 32'h0000_00B2;
        for (int i = 0; i < 6; i++) begin
            settle();
            check_ready($sformatf("rr%0d", i), 1'b0, (i % 2) == 0, (i % 2) == 1);
            tick();
            check($sformatf("rr%0d_addr", i), 32'(o_wr_address), (i % 2) == 0 ? 32'd1 : 32'd2);
            check($sformatf("rr%0d_we", i), 32'(o_we), 32'd1);
        end
        idle_inputs();
        tick();
        check("rr_wait_clear", 32'(o_alu_wait_cnt), 32'd0);

        // All three valid: debug wins 3 times, ALU waits, then ALU wins the tie.
        i_dbg_valid = 1'b1; i_dbg_addr = 5'd3; i_dbg_data = 32'h0000_0033;
        i_alu_valid = 1'b1;
        i_lsu_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            check_ready($sformatf("dbg%0d", i), 1'b1, 1'b0, 1'b0);
            tick();
            check($sformatf("dbg%0d_addr", i), 32'(o_wr_address), 32'd3);
            check($sformatf("dbg%0d_wait", i), 32'(o_alu_wait_cnt), 32'(i + 1));
        end
        i_dbg_valid = 1'b0;
        settle();
        check_ready("post_dbg", 1'b0, 1'b1, 1'b0);
        tick();
        check("post_dbg_addr", 32'(o_wr_address), 32'd1);
        check("post_dbg_wait", 32'(o_alu_wait_cnt), 32'd0);
        idle_inputs();

        // LSU write to x0: handshake, no write, but last_grant moves to LSU.
        i_lsu_valid = 1'b1; i_lsu_addr = 5'd0; i_lsu_data = 32'h0000_1234;
        settle();
        check_ready("x0", 1'b0, 1'b0, 1'b1);
        tick();
        i_lsu_valid = 1'b0;
        check("x0_we", 32'(o_we), 32'd0);
        check("x0_data", o_wr_data, 32'h0000_1234);
        i_alu_valid = 1'b1; i_alu_addr = 5'd9; i_alu_data = 32'h0000_0099;
        i_lsu_valid = 1'b1; i_lsu_addr = 5'd4;
        settle();
        check_ready("x0_tie", 1'b0, 1'b1, 1'b0);
        tick();
        check("x0_tie_addr", 32'(o_wr_address), 32'd9);
        idle_inputs();

        // Hold for 4 cycles with ALU valid: frozen grants, counter keeps running.
        i_hold = 1'b1;
        i_alu_valid = 1'b1; i_alu_addr = 5'd7; i_alu_data = 32'h0000_0077;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_ready($sformatf("hold%0d", i), 1'b0, 1'b0, 1'b0);
            tick();
            check($sformatf("hold%0d_we", i), 32'(o_we), 32'd0);
        end
        check("hold_wait", 32'(o_alu_wait_cnt), 32'd4);
        i_hold = 1'b0;
        settle();
        check_ready("unhold", 1'b0, 1'b1, 1'b0);
        tick();
        i_alu_valid = 1'b0;
        check("unhold_we", 32'(o_we), 32'd1);
        check("unhold_addr", 32'(o_wr_address), 32'd7);

        // Asynchronous reset drops the write before the next edge.
        rst = 1'b1;
        #1;
        check("async_rst_we", 32'(o_we), 32'd0);
        check("async_rst_addr", 32'(o_wr_address), 32'd0);
        check("async_rst_data", o_wr_data, 32'd0);
        rst = 1'b0;
        tick();
        check("final_we", 32'(o_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the single write port of the RV32I register file between three writeback sources: the ALU, the load/store unit (LSU) and the debug port. It grants one source per cycle using fixed priority for debug and round-robin between ALU and LSU. The granted write is registered and presented to the register file one cycle after the handshake. Writes to x0 are consumed without asserting the write enable.

## Interface

Parameters
- ADDR_WIDTH, 5, register address width (32 registers)
- DATA_WIDTH, 32, register data width

Ports
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- i_hold  in  1  pipeline hold; while high, no source is granted
- i_dbg_valid  in  1  debug write request
- i_dbg_addr  in  ADDR_WIDTH  debug destination register
- i_dbg_data  in  DATA_WIDTH  debug write data
- o_dbg_ready  out  1  debug request accepted this cycle
- i_alu_valid / i_alu_addr / i_alu_data / o_alu_ready  same widths  ALU writeback channel
- i_lsu_valid / i_lsu_addr / i_lsu_data / o_lsu_ready  same widths  LSU (load) writeback channel
- o_we  out  1  register file write enable
- o_wr_address  out  ADDR_WIDTH  register file write address
- o_wr_data  out  DATA_WIDTH  register file write data
- o_alu_wait_cnt  out  4  number of consecutive cycles the ALU has been valid and not granted (saturates at 15)

## Operation

- A handshake on a channel occurs when valid && ready are both high at a rising clk edge. A source must hold valid, addr and data stable until its handshake completes.
- ready is combinational from the valid inputs, i_hold and the round-robin state. At most one ready is high per cycle. ready is never high while its own valid is low.
- Grant order when i_hold=0:
  - Debug wins whenever i_dbg_valid=1.
  - Otherwise, if exactly one of ALU/LSU is valid, that source is granted.
  - If both are valid, the source that was not granted in the most recent ALU/LSU grant wins.
- last_grant register (1 bit: 0=ALU, 1=LSU):
  - Updated only on ALU or LSU handshakes.
  - Debug grants and idle cycles leave it unchanged.
  - Reset value is 1, so the ALU wins the first tie.
- When i_hold=1, all ready outputs are 0 and state is frozen. The wait counter still increments if the ALU is valid.
- Output register:
  - On any handshake, capture addr and data into o_wr_address/o_wr_data.
  - o_we is set to (addr != 0).
  - With no handshake, o_we=0 and address/data hold their previous values.
- An x0 request completes its handshake normally and updates last_grant, but produces no write.
- o_alu_wait_cnt:
  - Cleared on an ALU handshake, or whenever i_alu_valid=0.
  - Otherwise incremented each cycle, saturating at 15.
  - Used for stall profiling only; it does not alter priority.

## Timing

- Reset (async assert, sync deassert by the system): o_we=0, o_wr_address=0, o_wr_data=0, last_grant=1, o_alu_wait_cnt=0.
- ready outputs are 0 while rst=1.
- Latency: a handshake at edge N drives o_we/address/data during cycle N..N+1. The register file commits the write at edge N+1. There is no bypass; forwarding is the pipeline's responsibility.
- Throughput: one write per cycle sustained. Back-to-back grants to the same source are allowed when the other source is idle.
- Simultaneous requests from all three sources: debug granted. The ALU/LSU tie is resolved afterwards by the unchanged last_grant.
- i_hold rising in the same cycle as a valid: no handshake. The request remains pending.
- Reset asserted while o_we=1: the write is dropped immediately (o_we forced 0 asynchronously).
- Channels are independent. A valid raised in the cycle after another channel's handshake is eligible immediately.

## Test plan

- Reset then idle → o_we=0, o_wr_address=0, o_wr_data=0, all ready=0, o_alu_wait_cnt=0.
- ALU only: addr=5, data=0xDEADBEEF for one cycle → o_alu_ready=1 that cycle; next cycle o_we=1, addr=5, data=0xDEADBEEF; following cycle o_we=0.
- ALU and LSU continuously valid (ALU addr=1, LSU addr=2) for 6 cycles after reset → grants alternate ALU, LSU, ALU, LSU, ALU, LSU; o_wr_address sequence is 1,2,1,2,1,2.
- Debug, ALU and LSU all valid for 3 cycles → debug granted 3 times; o_alu_wait_cnt reaches 3; then ALU granted first and the counter returns to 0.
- LSU valid with addr=0, data=0x1234 → o_lsu_ready=1; next cycle o_we=0; a following ALU/LSU tie is won by the ALU.
- i_hold=1 for 4 cycles with ALU valid → no ready, o_we=0, o_alu_wait_cnt=4. Assert rst mid-write with o_we=1 → o_we drops to 0 before the next edge.
